// File: rtl/lcd_write_arbiter.sv
// Arbitrates all writes into the LCD frame RAM: PPU pass-through, white clear sweep, frame counting.
// Optional build macro LCD_CLEAR_ON_RESET_EN starts a full white sweep out of reset.
module lcd_write_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        slow_clk_en,
   input  logic        ppu_enable,
   input  logic [15:0] pixel_num,
   input  logic [14:0] pixel_color,
   input  logic        pixel_write,
   output logic [15:0] lcd_wraddress,
   output logic [14:0] lcd_data,
   output logic        lcd_wren,
   output logic        clearing,
   output logic        frame_done,
   output logic [7:0]  frame_count
);

   localparam logic [15:0] PIXELS     = 16'd23040;
   localparam logic [15:0] LAST_PIXEL = 16'd23039;
   localparam logic [14:0] WHITE      = 15'h7fff;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;

`ifdef LCD_CLEAR_ON_RESET_EN
   localparam logic [1:0] RESET_STATE = S_CLEAR;
`else
   localparam logic [1:0] RESET_STATE = S_IDLE;
`endif

   logic [1:0]  state_r;
   logic [15:0] clr_addr_r;

   logic [1:0]  state_s;
   logic [15:0] clr_addr_s;
   logic [15:0] wraddress_s;
   logic [14:0] data_s;
   logic        wren_s;
   logic        clearing_s;
   logic        frame_done_s;
   logic [7:0]  frame_count_s;
   logic        accept_s;

   // Next-state and next-output decode; every output is registered below.
   always_comb begin
      state_s       = state_r;
      clr_addr_s    = clr_addr_r;
      wraddress_s   = lcd_wraddress;
      data_s        = lcd_data;
      wren_s        = 1'b0;
      clearing_s    = 1'b0;
      frame_done_s  = 1'b0;
      frame_count_s = frame_count;
      accept_s      = slow_clk_en & pixel_write & (pixel_num < PIXELS);

      case (state_r)
         S_IDLE: begin
            if (ppu_enable) begin
               state_s = S_RUN;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_RUN: begin
            // Turning the PPU off wins over a same-cycle write strobe.
            if (!ppu_enable) begin
               state_s    = S_CLEAR;
               clr_addr_s = 16'd0;
            end else if (accept_s) begin
               wren_s      = 1'b1;
               wraddress_s = pixel_num;
               data_s      = pixel_color;
               if (pixel_num == LAST_PIXEL) begin
                  frame_done_s  = 1'b1;
                  frame_count_s = frame_count + 8'd1;
               end else begin
                  frame_done_s  = 1'b0;
               end
            end else begin
               wren_s = 1'b0;
            end
         end
         S_CLEAR: begin
            wren_s      = 1'b1;
            clearing_s  = 1'b1;
            wraddress_s = clr_addr_r;
            data_s      = WHITE;
            // ppu_enable is only consulted at the end, so toggles never abort the sweep.
            if (clr_addr_r == LAST_PIXEL) begin
               clr_addr_s = 16'd0;
               if (ppu_enable) begin
                  state_s = S_RUN;
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               clr_addr_s = clr_addr_r + 16'd1;
            end
         end
         default: begin
            state_s    = S_IDLE;
            clr_addr_s = 16'd0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= RESET_STATE;
         clr_addr_r    <= 16'd0;
         lcd_wraddress <= 16'd0;
         lcd_data      <= 15'd0;
         lcd_wren      <= 1'b0;
         clearing      <= 1'b0;
         frame_done    <= 1'b0;
         frame_count   <= 8'd0;
      end else begin
         state_r       <= state_s;
         clr_addr_r    <= clr_addr_s;
         lcd_wraddress <= wraddress_s;
         lcd_data      <= data_s;
         lcd_wren      <= wren_s;
         clearing      <= clearing_s;
         frame_done    <= frame_done_s;
         frame_count   <= frame_count_s;
      end
   end

endmodule

// File: doc/lcd_write_arbiter.md
# lcd_write_arbiter

Sits between the console's pixel output and the dual-clock LCD frame RAM write port, and owns every write into that RAM. While the PPU is on it forwards pixel writes qualified by the slow clock enable. When the PPU turns off it sweeps the whole 160x144 frame to white with a dedicated state machine. It also tracks completed frames for status display.

## Interface
- PIXELS, 23040, number of LCD pixels (160x144); valid addresses 0..PIXELS-1
- WHITE, 15'h7fff, RGB555 colour used by the clear sweep
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-high
- slow_clk_en  in  1  console clock enable; pixel writes count only when high
- ppu_enable  in  1  LCDC[7] from console
- pixel_num  in  16  pixel address from PPU
- pixel_color  in  15  RGB555 pixel from PPU
- pixel_write  in  1  PPU write strobe
- lcd_wraddress  out  16  frame RAM write address
- lcd_data  out  15  frame RAM write data
- lcd_wren  out  1  frame RAM write enable
- clearing  out  1  high while the sweep runs
- frame_done  out  1  one-cycle pulse on completion of a frame
- frame_count  out  8  completed-frame counter, wraps

## Operation
- States: IDLE (PPU off, frame cleared), RUN (pass-through), CLEAR (sweep).
- Internal counters:
  - 16-bit clear counter clr_addr.
  - 16-bit dropped-write counter is not required.
- IDLE:
  - ppu_enable=1 -> RUN.
  - lcd_wren=0.
- RUN:
  - An accepted write is slow_clk_en & pixel_write & (pixel_num < PIXELS).
  - An accepted write drives lcd_wraddress=pixel_num, lcd_data=pixel_color, lcd_wren=1.
  - pixel_num >= PIXELS is suppressed (lcd_wren=0), with no other effect.
  - An accepted write with pixel_num == PIXELS-1 pulses frame_done. frame_count then increments modulo 256.
  - ppu_enable=0 -> CLEAR with clr_addr=0. A write strobe in that same cycle is dropped.
- CLEAR:
  - Every cycle, independent of slow_clk_en, writes WHITE at clr_addr, then increments clr_addr.
  - When the write at clr_addr == PIXELS-1 is issued, the next state is RUN if ppu_enable=1, else IDLE.
  - PPU writes arriving during CLEAR are dropped.
  - A ppu_enable toggle mid-sweep does not restart or abort the sweep.
  - clearing=1 for exactly the cycles whose lcd_wren comes from the sweep.
- Width rules:
  - Comparisons against PIXELS are unsigned 16-bit.
  - clr_addr never exceeds PIXELS-1.
  - frame_count wraps 255 -> 0 silently.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency is 1 cycle: a write accepted at edge N appears on lcd_* after edge N, and RAM sees it at edge N+1.
- Sweep timing:
  - The first sweep write (address 0) appears the cycle after the RUN->CLEAR edge.
  - The sweep produces exactly PIXELS consecutive lcd_wren=1 cycles with addresses 0..PIXELS-1 ascending.
  - clearing falls together with the last sweep write's deassertion.
- frame_done is asserted in the same cycle as the lcd_wren of the final pixel.
- Reset values, applied asynchronously:
  - Outputs: lcd_wraddress=0, lcd_data=0, lcd_wren=0, clearing=0, frame_done=0, frame_count=0.
  - Internal: clr_addr=0, state=IDLE (macro-dependent, see Configuration).
- Reset asserted mid-sweep aborts it immediately; no further writes occur.
- Reset asserted mid-frame drops the pending output write.

## Configuration
- LCD_CLEAR_ON_RESET_EN, when defined:
  - Reset state is CLEAR with clr_addr=0.
  - After reset release a full white sweep runs (PIXELS cycles), then the block goes to RUN or IDLE per ppu_enable.
  - The RAM power-up content never reaches the display.
- When undefined:
  - Reset state is IDLE.
  - The first sweep happens only on a RUN->CLEAR transition.

## Test plan
- Pass-through:
  - Stimulus: ppu_enable=1, slow_clk_en=1, pixel_write=1, pixel_num=16'd100, pixel_color=15'h1234.
  - Required: next cycle lcd_wren=1, lcd_wraddress=100, lcd_data=15'h1234.
  - Same stimulus with slow_clk_en=0: lcd_wren=0.
- Sweep on PPU off:
  - Stimulus: in RUN, drop ppu_enable to 0.
  - Required: 23040 consecutive writes of 15'h7fff at addresses 0..23039, clearing=1 throughout, then IDLE with lcd_wren=0.
- Mid-sweep events:
  - Stimulus: raise ppu_enable and pulse pixel_write (pixel_num=5) at sweep address 1000.
  - Required: the write is dropped, the sweep completes to 23039, and the block enters RUN.
- Range and frame counting:
  - Stimulus: pixel_num=23040 with a valid strobe.
  - Required: no lcd_wren.
  - Stimulus: 256 accepted writes at 23039.
  - Required: 256 single-cycle frame_done pulses, frame_count back to 0.
- Reset mid-sweep:
  - Stimulus: assert reset at sweep address 500, asynchronous to clk.
  - Required: lcd_wren=0 and clearing=0 immediately, all outputs at reset values.
- Macro:
  - With LCD_CLEAR_ON_RESET_EN, release reset with ppu_enable=1: full 23040-write sweep, then RUN.
  - Without the macro: no sweep; RUN one cycle after release.
